// File: rtl/mem_hier_pkg.sv
// Shared encodings, cache geometry and FSM state type for the mem_hier
// write-back cache and its backing memory.
package mem_hier_pkg;
   localparam int NUM_WAYS   = 2;
   localparam int NUM_SETS   = 32;
   localparam int LINE_WORDS = 4;
   localparam int TAG_W      = 23;
   localparam int IDX_W      = 5;
   localparam int OFF_W      = 4;
   localparam int MEM_DEPTH  = 1024;
   localparam int MEM_AW     = 10;

   localparam logic [1:0] WR_NONE = 2'b00;
   localparam logic [1:0] WR_SB   = 2'b01;
   localparam logic [1:0] WR_SH   = 2'b10;
   localparam logic [1:0] WR_SW   = 2'b11;

   localparam logic [2:0] RD_NONE = 3'b000;
   localparam logic [2:0] RD_LB   = 3'b001;
   localparam logic [2:0] RD_LH   = 3'b010;
   localparam logic [2:0] RD_LW   = 3'b011;
   localparam logic [2:0] RD_LBU  = 3'b100;
   localparam logic [2:0] RD_LHU  = 3'b101;

   typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;

   function automatic logic [3:0] store_be(input logic [1:0] ctrl, input logic [1:0] off);
      case (ctrl)
         WR_NONE: return 4'b0000;
         WR_SB:   return 4'b0001 << off;
         WR_SH:   return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] old_word, input logic [31:0] wd,
                                               input logic [1:0] ctrl, input logic [1:0] off);
      logic [31:0] rep;
      logic [31:0] res;
      logic [3:0]  be;
      case (ctrl)
         WR_SB:   rep = {4{wd[7:0]}};
         WR_SH:   rep = {2{wd[15:0]}};
         default: rep = wd;
      endcase
      be  = store_be(ctrl, off);
      res = old_word;
      for (int i = 0; i < 4; i++)
         if (be[i]) res[8*i +: 8] = rep[8*i +: 8];
      return res;
   endfunction

   function automatic logic [31:0] load_extract(input logic [2:0] ctrl, input logic [31:0] w,
                                                input logic [1:0] off);
      logic [31:0] sh;
      logic [15:0] h;
      sh = w >> {off, 3'b000};
      h  = off[1] ? w[31:16] : w[15:0];
      case (ctrl)
         RD_LB:   return {{24{sh[7]}}, sh[7:0]};
         RD_LH:   return {{16{h[15]}}, h};
         RD_LBU:  return {24'b0, sh[7:0]};
         RD_LHU:  return {16'b0, h};
         RD_LW:   return w;
         default: return w;
      endcase
   endfunction
endpackage

// File: rtl/mem_hier_main_mem.sv
// 1024x32 backing store with a single synchronous port; read data is
// registered and returns the pre-write contents on a write cycle.
module mem_hier_main_mem
   import mem_hier_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [MEM_AW-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);
   logic [31:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end
endmodule

// File: rtl/mem_hier.sv
// 2-way set-associative write-back, write-allocate cache (1 KiB, LRU) in
// front of a 1024-word backing memory.
//   IDLE      | waiting for a request; latches it
//   LOOKUP    | tag compare, victim choice
//   WRITEBACK | dirty victim line to memory
//   REFILL    | line from memory into the victim way
//   RESPOND   | access performed, pulse registered
module mem_hier
   import mem_hier_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        read_req,
   input  logic        write_req,
   input  logic [31:0] addr,
   input  logic [1:0]  wr_ctrl,
   input  logic [2:0]  rd_ctrl,
   input  logic [31:0] wr_data,
   output logic        rd_data_valid,
   output logic        wr_ready,
   output logic [31:0] rd_data
);
   state_t      state;
   logic        is_write;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_wr_ctrl;
   logic [2:0]  req_rd_ctrl;
   logic [1:0]  beat;
   logic        way_q;

   logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid, dirty;
   logic [NUM_SETS-1:0]               lru;
   logic [TAG_W-1:0] tag_q  [NUM_WAYS][NUM_SETS];
   logic [31:0]      data_q [NUM_WAYS][NUM_SETS][LINE_WORDS];

   logic [TAG_W-1:0] req_tag, wb_tag;
   logic [IDX_W-1:0] idx;
   logic [1:0]       word, off, beat_word, beat_word_nxt;
   logic             hit0, hit1, hit, victim_way, victim_dirty, wb_way;
   logic [31:0]      cur_word;

   logic              mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_wdata, mem_rdata;

   assign req_tag       = req_addr[31 -: TAG_W];
   assign idx           = req_addr[OFF_W +: IDX_W];
   assign word          = req_addr[3:2];
   assign off           = req_addr[1:0];
   assign beat_word     = ~beat;
   assign beat_word_nxt = beat_word + 2'd1;

   assign hit0         = valid[idx][0] && (tag_q[0][idx] == req_tag);
   assign hit1         = valid[idx][1] && (tag_q[1][idx] == req_tag);
   assign hit          = hit0 || hit1;
   assign victim_way   = hit ? hit1 : !valid[idx][0] ? 1'b0 : !valid[idx][1] ? 1'b1 : lru[idx];
   assign victim_dirty = valid[idx][victim_way] && dirty[idx][victim_way];
   assign wb_way       = (state == LOOKUP) ? victim_way : way_q;
   assign wb_tag       = tag_q[wb_way][idx];
   assign cur_word     = data_q[way_q][idx][word];

   // The port is shifted one beat early: victim word 0 goes out in LOOKUP so the
   // last WRITEBACK beat can prefetch refill word 0 and REFILL stays 4 beats.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = {req_tag[2:0], idx, 2'd0};
      mem_wdata = '0;
      case (state)
         LOOKUP:
            if (!hit && victim_dirty) begin
               mem_we    = 1'b1;
               mem_addr  = {wb_tag[2:0], idx, 2'd0};
               mem_wdata = data_q[victim_way][idx][0];
            end
         WRITEBACK:
            if (beat != 2'd0) begin
               mem_we    = 1'b1;
               mem_addr  = {wb_tag[2:0], idx, beat_word_nxt};
               mem_wdata = data_q[way_q][idx][beat_word_nxt];
            end
         REFILL:  mem_addr = {req_tag[2:0], idx, beat_word_nxt};
         default: ;
      endcase
   end

   mem_hier_main_mem u_main_mem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         valid         <= '0;
         dirty         <= '0;
         lru           <= '0;
         rd_data_valid <= 1'b0;
         wr_ready      <= 1'b0;
         rd_data       <= '0;
         beat          <= '0;
         way_q         <= 1'b0;
         is_write      <= 1'b0;
         req_addr      <= '0;
         req_wdata     <= '0;
         req_wr_ctrl   <= '0;
         req_rd_ctrl   <= '0;
      end else begin
         rd_data_valid <= 1'b0;
         wr_ready      <= 1'b0;
         case (state)
            IDLE:
               if (write_req || read_req) begin
                  is_write    <= write_req;
                  req_addr    <= addr;
                  req_wdata   <= wr_data;
                  req_wr_ctrl <= wr_ctrl;
                  req_rd_ctrl <= rd_ctrl;
                  state       <= LOOKUP;
               end
            LOOKUP: begin
               way_q <= victim_way;
               beat  <= 2'd3;
               if (hit)               state <= RESPOND;
               else if (victim_dirty) state <= WRITEBACK;
               else                   state <= REFILL;
            end
            WRITEBACK:
               if (beat == 2'd0) begin
                  beat  <= 2'd3;
                  state <= REFILL;
               end else begin
                  beat <= beat - 2'd1;
               end
            REFILL:
               if (beat == 2'd0) begin
                  valid[idx][way_q] <= 1'b1;
                  dirty[idx][way_q] <= 1'b0;
                  state             <= RESPOND;
               end else begin
                  beat <= beat - 2'd1;
               end
            RESPOND: begin
               lru[idx] <= ~way_q;
               if (is_write) begin
                  wr_ready <= 1'b1;
                  if (store_be(req_wr_ctrl, off) != 4'b0000) dirty[idx][way_q] <= 1'b1;
               end else begin
                  rd_data_valid <= 1'b1;
                  if (req_rd_ctrl != RD_NONE) rd_data <= load_extract(req_rd_ctrl, cur_word, off);
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == REFILL) begin
         data_q[way_q][idx][beat_word] <= mem_rdata;
         if (beat == 2'd0) tag_q[way_q][idx] <= req_tag;
      end else if (state == RESPOND && is_write) begin
         data_q[way_q][idx][word] <= store_merge(cur_word, req_wdata, req_wr_ctrl, off);
      end
   end
endmodule

// File: tb/tb_mem_hier.sv
// Directed bench for mem_hier: table of requests with expected latency,
// pulse kind and load data, plus busy-ignore and reset-abort sequences.
module tb_mem_hier;
   import mem_hier_pkg::*;

   logic        clk, rst, read_req, write_req;
   logic [31:0] addr, wr_data, rd_data;
   logic [1:0]  wr_ctrl;
   logic [2:0]  rd_ctrl;
   logic        rd_data_valid, wr_ready;

   int n_checks = 0;
   int n_pass   = 0;

   mem_hier dut (
      .clk           (clk),
      .rst           (rst),
      .read_req      (read_req),
      .write_req     (write_req),
      .addr          (addr),
      .wr_ctrl       (wr_ctrl),
      .rd_ctrl       (rd_ctrl),
      .wr_data       (wr_data),
      .rd_data_valid (rd_data_valid),
      .wr_ready      (wr_ready),
      .rd_data       (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      bit          both;
      logic [31:0] a;
      logic [1:0]  wc;
      logic [2:0]  rc;
      logic [31:0] wd;
      int          lat;
      bit          chk;
      logic [31:0] rd;
   } vec_t;

   vec_t vecs[26];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic do_req(input bit wr, input bit both, input logic [31:0] a, input logic [1:0] wc,
                         input logic [2:0] rc, input logic [31:0] wd, output int lat,
                         output logic [1:0] kind, output logic [31:0] rdat, output bit single);
      @(negedge clk);
      write_req = wr;
      read_req  = !wr || both;
      addr      = a;
      wr_ctrl   = wc;
      rd_ctrl   = rc;
      wr_data   = wd;
      @(posedge clk);
      #1;
      write_req = 1'b0;
      read_req  = 1'b0;
      lat = -1; kind = 2'b00; rdat = '0; single = 1'b0;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk);
         #1;
         if (rd_data_valid || wr_ready) begin
            lat  = n;
            kind = {wr_ready, rd_data_valid};
            rdat = rd_data;
            break;
         end
      end
      if (lat > 0) begin
         @(posedge clk);
         #1;
         single = !(rd_data_valid || wr_ready);
      end
   endtask

   initial begin
      int          lat, pulses, wr_cnt, rd_cnt, wr_lat;
      logic [1:0]  kind;
      logic [31:0] rdat;
      bit          single;

      //           wr    both  addr         wc       rc       wdata         lat chk rd
      vecs[0]  = '{1'b1, 1'b0, 32'h0000_0001, WR_SW,   RD_NONE, 32'h0000_0001, 6,  1'b0, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 32'h0000_0001, WR_SW,   RD_NONE, 32'h0000_0001, 2,  1'b0, 32'h0};
      vecs[2]  = '{1'b0, 1'b0, 32'h0000_0001, WR_NONE, RD_LW,   32'h0,         2,  1'b1, 32'h0000_0001};
      vecs[3]  = '{1'b1, 1'b0, 32'h0000_0201, WR_SW,   RD_NONE, 32'h0000_0001, 6,  1'b0, 32'h0};
      vecs[4]  = '{1'b0, 1'b0, 32'h0000_0201, WR_NONE, RD_LW,   32'h0,         2,  1'b1, 32'h0000_0001};
      vecs[5]  = '{1'b1, 1'b0, 32'h0000_0401, WR_SW,   RD_NONE, 32'h0000_0001, 10, 1'b0, 32'h0};
      vecs[6]  = '{1'b0, 1'b0, 32'h0000_0401, WR_NONE, RD_LW,   32'h0,         2,  1'b1, 32'h0000_0001};
      vecs[7]  = '{1'b0, 1'b0, 32'h0000_0001, WR_NONE, RD_LW,   32'h0,         10, 1'b1, 32'h0000_0001};
      vecs[8]  = '{1'b1, 1'b0, 32'h0000_0010, WR_SW,   RD_NONE, 32'h80FF_7F01, 6,  1'b0, 32'h0};
      vecs[9]  = '{1'b0, 1'b0, 32'h0000_0013, WR_NONE, RD_LB,   32'h0,         2,  1'b1, 32'hFFFF_FF80};
      vecs[10] = '{1'b0, 1'b0, 32'h0000_0013, WR_NONE, RD_LBU,  32'h0,         2,  1'b1, 32'h0000_0080};
      vecs[11] = '{1'b0, 1'b0, 32'h0000_0012, WR_NONE, RD_LH,   32'h0,         2,  1'b1, 32'hFFFF_80FF};
      vecs[12] = '{1'b0, 1'b0, 32'h0000_0010, WR_NONE, RD_LHU,  32'h0,         2,  1'b1, 32'h0000_7F01};
      vecs[13] = '{1'b0, 1'b0, 32'h0000_0011, WR_NONE, RD_LW,   32'h0,         2,  1'b1, 32'h80FF_7F01};
      vecs[14] = '{1'b0, 1'b0, 32'h0000_0013, WR_NONE, RD_LH,   32'h0,         2,  1'b1, 32'hFFFF_80FF};
      vecs[15] = '{1'b1, 1'b0, 32'h0000_0012, WR_SB,   RD_NONE, 32'h0000_00AB, 2,  1'b0, 32'h0};
      vecs[16] = '{1'b0, 1'b0, 32'h0000_0010, WR_NONE, RD_LW,   32'h0,         2,  1'b1, 32'h80AB_7F01};
      vecs[17] = '{1'b1, 1'b0, 32'h0000_0011, WR_SH,   RD_NONE, 32'h1234_CDEF, 2,  1'b0, 32'h0};
      vecs[18] = '{1'b0, 1'b0, 32'h0000_0010, WR_NONE, RD_LW,   32'h0,         2,  1'b1, 32'h80AB_CDEF};
      vecs[19] = '{1'b1, 1'b0, 32'h0000_0010, WR_NONE, RD_NONE, 32'hFFFF_FFFF, 2,  1'b0, 32'h0};
      vecs[20] = '{1'b0, 1'b0, 32'h0000_0010, WR_NONE, RD_NONE, 32'h0,         2,  1'b1, 32'h80AB_CDEF};
      vecs[21] = '{1'b0, 1'b0, 32'h0000_0010, WR_NONE, RD_LW,   32'h0,         2,  1'b1, 32'h80AB_CDEF};
      vecs[22] = '{1'b0, 1'b0, 32'h0000_0012, WR_NONE, 3'b111,  32'h0,         2,  1'b1, 32'h80AB_CDEF};
      vecs[23] = '{1'b0, 1'b0, 32'h0000_0011, WR_NONE, RD_LB,   32'h0,         2,  1'b1, 32'hFFFF_FFCD};
      vecs[24] = '{1'b1, 1'b1, 32'h0000_0014, WR_SW,   RD_LW,   32'h0000_0077, 2,  1'b0, 32'h0};
      vecs[25] = '{1'b0, 1'b0, 32'h0000_0014, WR_NONE, RD_LW,   32'h0,         2,  1'b1, 32'h0000_0077};

      rst = 1'b0; read_req = 1'b0; write_req = 1'b0;
      addr = '0; wr_ctrl = '0; rd_ctrl = '0; wr_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset rd_data_valid", {31'b0, rd_data_valid}, 32'h0);
      check("reset wr_ready", {31'b0, wr_ready}, 32'h0);
      check("reset rd_data", rd_data, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 26; i++) begin
         do_req(vecs[i].wr, vecs[i].both, vecs[i].a, vecs[i].wc, vecs[i].rc, vecs[i].wd,
                lat, kind, rdat, single);
         check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("v%0d pulse kind", i), {30'b0, kind}, vecs[i].wr ? 32'h2 : 32'h1);
         check($sformatf("v%0d single-cycle pulse", i), {31'b0, single}, 32'h1);
         if (vecs[i].chk) check($sformatf("v%0d rd_data", i), rdat, vecs[i].rd);
      end

      // read requests held while a store miss is busy must be dropped
      @(negedge clk);
      write_req = 1'b1; addr = 32'h20; wr_ctrl = WR_SW; rd_ctrl = RD_LW; wr_data = 32'h55;
      @(posedge clk);
      #1;
      write_req = 1'b0;
      read_req  = 1'b1;
      wr_cnt = 0; rd_cnt = 0; wr_lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (c == 3) read_req = 1'b0;
         if (wr_ready) begin wr_cnt++; wr_lat = c; end
         if (rd_data_valid) rd_cnt++;
      end
      check("busy store pulse count", 32'(wr_cnt), 32'd1);
      check("busy store latency", 32'(wr_lat), 32'd6);
      check("busy read ignored", 32'(rd_cnt), 32'd0);
      do_req(1'b0, 1'b0, 32'h20, WR_NONE, RD_LW, 32'h0, lat, kind, rdat, single);
      check("busy line hit latency", 32'(lat), 32'd2);
      check("busy line data", rdat, 32'h55);

      // reset in the middle of a refill aborts with no pulse
      @(negedge clk);
      read_req = 1'b1; addr = 32'h30; rd_ctrl = RD_LW;
      @(posedge clk);
      #1;
      read_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) rst = 1'b1;
         if (rd_data_valid || wr_ready) pulses++;
      end
      check("abort no pulse", 32'(pulses), 32'd0);
      do_req(1'b0, 1'b0, 32'h30, WR_NONE, RD_LW, 32'h0, lat, kind, rdat, single);
      check("after abort line misses", 32'(lat), 32'd6);
      do_req(1'b0, 1'b0, 32'h1, WR_NONE, RD_LW, 32'h0, lat, kind, rdat, single);
      check("after reset set0 misses", 32'(lat), 32'd6);
      check("memory kept written-back word", rdat, 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mem_hier.md
MEM_HIER -- requirements
Module: mem_hier

Interface
REQ-001 clk  in  1  sole clock; all state changes on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 read_req  in  1  one-cycle load request pulse, sampled only in IDLE.
REQ-004 write_req  in  1  one-cycle store request pulse, sampled only in IDLE.
REQ-005 addr  in  32  byte address: tag [31:9], index [8:4], offset [3:0].
REQ-006 wr_ctrl  in  2  store size: 00 none, 01 SB, 10 SH, 11 SW.
REQ-007 rd_ctrl  in  3  load type: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; others are treated as LW.
REQ-008 wr_data  in  32  store data; the low byte or halfword is used for SB/SH.
REQ-009 rd_data_valid  out  1  one-cycle pulse; rd_data is valid in that cycle.
REQ-010 wr_ready  out  1  one-cycle pulse; the store has completed in the cache.
REQ-011 rd_data  out  32  load result, sign- or zero-extended; holds its value between loads.

Function
REQ-012 Cache geometry: 2-way set-associative, 32 sets, 16-byte lines (4 words), 1 KiB total; each way has valid, dirty, a 23-bit tag and 4 words; each set has 1 LRU bit.
REQ-013 Policies: write-back, write-allocate, LRU replacement; an invalid way is chosen before the LRU way.
REQ-014 Backing memory: internal 1024-word array indexed by address [11:2]; address bits [31:12] alias; contents are zero at power-up and are not reset.
REQ-015 FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
REQ-016 IDLE -> LOOKUP on write_req or read_req; addr, wr_ctrl, rd_ctrl and wr_data are latched at that edge; write_req takes priority if both are asserted.
REQ-017 In LOOKUP, a hit goes to RESPOND. A miss with a clean or invalid victim goes to REFILL. A miss with a dirty victim goes to WRITEBACK.
REQ-018 WRITEBACK writes 4 words to memory, one per cycle, at {victim tag, index, word}, then goes to REFILL.
REQ-019 REFILL reads 4 words from memory, one per cycle, into the victim way; it sets valid, clears dirty, loads the tag, then goes to RESPOND.
REQ-020 RESPOND performs the access in one cycle:
- stores merge bytes using the enables and set dirty;
- loads extract and extend the data;
- the LRU bit is updated to point at the other way;
- the matching output pulse is asserted for exactly one cycle;
- the FSM then returns to IDLE.
REQ-021 Latency, counted from the request-sampling edge: hit = response pulse after edge 2; clean miss = after edge 6; dirty miss = after edge 10.
REQ-022 Requests arriving outside IDLE are ignored and are not queued.
REQ-023 Alignment: word access uses offset [3:2] and ignores [1:0]; halfword uses [3:1] and ignores [0]; byte uses [3:0]; little-endian.
REQ-024 A store or load with a none encoding still completes with its pulse, with no data change.

Reset
REQ-025 When rst is low: FSM = IDLE, all valid, dirty and LRU bits = 0, rd_data_valid = 0, wr_ready = 0, rd_data = 0.
REQ-026 Reset asserted mid-operation aborts the access immediately; no response pulse is produced; memory keeps any words already written.

Structure
REQ-027 Package mem_hier_pkg holds the wr_ctrl/rd_ctrl encodings, geometry constants (ways, sets, line words, tag/index/offset widths), the memory depth and the FSM state enum.
REQ-028 The backing memory is a sub-module mem_hier_main_mem: synchronous 1-word read/write port, 1024x32.

Verification
REQ-029 Cold store SW 0x1 at addr 0x00000001 -> clean miss refill; wr_ready after edge 6; set 0 way0 valid, dirty, tag 0.
REQ-030 Repeat the same SW -> hit; wr_ready after edge 2; no memory traffic.
REQ-031 LW at 0x00000001 -> hit; rd_data_valid after edge 2 with rd_data = 0x00000001.
REQ-032 SW 0x1 at 0x00000201 (tag 1), then LW at the same address -> way1 is filled, LW hits and returns 1; then SW at 0x00000401 (tag 2) -> LRU way0 is evicted dirty; wr_ready after edge 10; memory word 0 = 1; LW 0x00000401 returns 1.
REQ-033 Byte/half: SW 0x80FF7F01 to a line; LB at offset 3 -> 0xFFFFFF80; LBU -> 0x00000080; LH at offset 2 -> 0xFFFF80FF; LHU at offset 0 -> 0x00007F01.
REQ-034 Reset pulse during REFILL -> FSM returns to IDLE, no pulse; a following LW of that line misses.
